// File: rtl/det_matrix_loader.sv
// Front end for the 8x8 determinant engine: collects 64 4-bit entries via Enter/Back
// buttons into a flat 256-bit bus, then runs the Start/Ack handshake with the engine.
module det_matrix_loader #(
  parameter bit CLEAR_ON_ACK = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [3:0]   Din,
  input  logic         BtnEnter,
  input  logic         BtnBack,
  input  logic         DetBusy,
  input  logic         DetDone,
  output logic [255:0] input_arr_flat,
  output logic         Start,
  output logic         Ack,
  output logic [5:0]   EntryIdx,
  output logic         q_Fill,
  output logic         q_Req,
  output logic         q_Wait,
  output logic         q_Show
);

  // One-hot encoding so any corrupted pattern falls into the recovery branch.
  typedef enum logic [3:0] {
    S_FILL = 4'b0001,
    S_REQ  = 4'b0010,
    S_WAIT = 4'b0100,
    S_SHOW = 4'b1000
  } state_t;

  state_t       state_q, state_nxt;
  logic [5:0]   idx_nxt;
  logic         start_nxt, ack_nxt;
  logic         wr_en, clr_arr;
  logic         enter_prev, back_prev;
  logic         enter_ev, back_ev;

  assign enter_ev = BtnEnter & ~enter_prev;
  assign back_ev  = BtnBack  & ~back_prev;

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = EntryIdx;
    ack_nxt   = Ack;
    wr_en     = 1'b0;
    clr_arr   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (enter_ev && !back_ev) begin
          wr_en = 1'b1;
          if (EntryIdx == 6'd63) state_nxt = S_REQ;
          else                   idx_nxt   = EntryIdx + 6'd1;
        end else if (back_ev && !enter_ev) begin
          if (EntryIdx != 6'd0) idx_nxt = EntryIdx - 6'd1;
        end
      end
      S_REQ:  if (DetBusy) state_nxt = S_WAIT;
      S_WAIT: if (DetDone) state_nxt = S_SHOW;
      S_SHOW: begin
        // Ack is held until the engine leaves DONE, then we return to entry.
        if (Ack && !DetDone) begin
          ack_nxt   = 1'b0;
          idx_nxt   = 6'd0;
          clr_arr   = CLEAR_ON_ACK;
          state_nxt = S_FILL;
        end else if (enter_ev) begin
          ack_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_FILL;
        idx_nxt   = 6'd0;
        ack_nxt   = 1'b0;
        clr_arr   = 1'b1;
      end
    endcase
    start_nxt = (state_nxt == S_REQ);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_FILL;
      EntryIdx       <= 6'd0;
      Start          <= 1'b0;
      Ack            <= 1'b0;
      enter_prev     <= 1'b1;
      back_prev      <= 1'b1;
      input_arr_flat <= '0;
    end else begin
      state_q    <= state_nxt;
      EntryIdx   <= idx_nxt;
      Start      <= start_nxt;
      Ack        <= ack_nxt;
      enter_prev <= BtnEnter;
      back_prev  <= BtnBack;
      if (clr_arr)
        input_arr_flat <= '0;
      else if (wr_en)
        input_arr_flat[{EntryIdx, 2'b00} +: 4] <= Din;
    end
  end

  assign q_Fill = state_q[0];
  assign q_Req  = state_q[1];
  assign q_Wait = state_q[2];
  assign q_Show = state_q[3];

endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed bench for det_matrix_loader: entry, edit, edge handling, engine handshake
// and asynchronous reset, on one instance clearing on Ack and one keeping the matrix.
module tb_det_matrix_loader;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [3:0]   Din;
  logic         BtnEnter, BtnBack, DetBusy, DetDone;

  logic [255:0] arr_c, arr_k;
  logic         start_c, ack_c, fill_c, req_c, wait_c, show_c;
  logic         start_k, ack_k, fill_k, req_k, wait_k, show_k;
  logic [5:0]   idx_c, idx_k;

  int n_chk  = 0;
  int n_fail = 0;
  logic [255:0] exp_arr;

  det_matrix_loader #(.CLEAR_ON_ACK(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset), .Din(Din), .BtnEnter(BtnEnter), .BtnBack(BtnBack),
    .DetBusy(DetBusy), .DetDone(DetDone), .input_arr_flat(arr_c), .Start(start_c),
    .Ack(ack_c), .EntryIdx(idx_c), .q_Fill(fill_c), .q_Req(req_c), .q_Wait(wait_c),
    .q_Show(show_c)
  );

  det_matrix_loader #(.CLEAR_ON_ACK(1'b0)) u_keep (
    .Clk(Clk), .Reset(Reset), .Din(Din), .BtnEnter(BtnEnter), .BtnBack(BtnBack),
    .DetBusy(DetBusy), .DetDone(DetDone), .input_arr_flat(arr_k), .Start(start_k),
    .Ack(ack_k), .EntryIdx(idx_k), .q_Fill(fill_k), .q_Req(req_k), .q_Wait(wait_k),
    .q_Show(show_k)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ent(input logic [255:0] a, input int k);
    return a[k*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press_enter(input logic [3:0] d);
    Din = d;
    BtnEnter = 1'b1;
    tick();
    BtnEnter = 1'b0;
    tick();
  endtask

  task automatic press_back();
    BtnBack = 1'b1;
    tick();
    BtnBack = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b1; Din = 4'd0; BtnEnter = 1'b0; BtnBack = 1'b0;
    DetBusy = 1'b0; DetDone = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();

    chk("rst_idx",   idx_c, 6'd0);
    chk("rst_fill",  {fill_c, req_c, wait_c, show_c}, 4'b1000);
    chk("rst_start", start_c, 1'b0);
    chk("rst_ack",   ack_c, 1'b0);
    chk("rst_arr",   arr_c, '0);

    press_back();
    chk("back_at_0", idx_c, 6'd0);

    press_enter(4'd5); press_enter(4'd7); press_enter(4'd9);
    chk("idx_after3", idx_c, 6'd3);
    press_back(); press_back();
    chk("idx_after_back", idx_c, 6'd1);
    press_enter(4'd3);
    chk("edit_e0", ent(arr_c, 0), 4'd5);
    chk("edit_e1", ent(arr_c, 1), 4'd3);
    chk("edit_e2", ent(arr_c, 2), 4'd9);
    chk("edit_idx", idx_c, 6'd2);

    // Held Enter: only the rising edge writes; later Din changes are ignored.
    Din = 4'd4; BtnEnter = 1'b1;
    tick();
    Din = 4'd6;
    repeat (19) tick();
    BtnEnter = 1'b0;
    tick();
    chk("hold_e2",  ent(arr_c, 2), 4'd4);
    chk("hold_e3",  ent(arr_c, 3), 4'd0);
    chk("hold_idx", idx_c, 6'd3);

    Din = 4'd8; BtnEnter = 1'b1; BtnBack = 1'b1;
    tick();
    BtnEnter = 1'b0; BtnBack = 1'b0;
    tick();
    chk("simul_idx", idx_c, 6'd3);
    chk("simul_e3",  ent(arr_c, 3), 4'd0);

    Reset = 1'b1; tick(); Reset = 1'b0; tick();
    exp_arr = '0;
    for (int k = 0; k < 63; k++) begin
      press_enter(4'(k % 16));
      exp_arr[k*4 +: 4] = 4'(k % 16);
    end
    exp_arr[63*4 +: 4] = 4'd15;
    chk("pre64_fill",  fill_c, 1'b1);
    chk("pre64_start", start_c, 1'b0);
    Din = 4'd15; BtnEnter = 1'b1;
    tick();
    chk("f64_req",   req_c, 1'b1);
    chk("f64_start", start_c, 1'b1);
    chk("f64_idx",   idx_c, 6'd63);
    BtnEnter = 1'b0;
    tick();
    chk("fill_arr",  arr_c, exp_arr);
    chk("fill_arrk", arr_k, exp_arr);

    press_enter(4'd0); press_back();
    chk("req_ign_arr",   arr_c, exp_arr);
    chk("req_ign_state", {fill_c, req_c, wait_c, show_c}, 4'b0100);
    chk("req_ign_start", start_c, 1'b1);
    chk("req_ign_idx",   idx_c, 6'd63);

    DetBusy = 1'b1;
    tick();
    chk("busy_start", start_c, 1'b0);
    chk("busy_wait",  wait_c, 1'b1);

    press_enter(4'd1); press_back();
    chk("wait_ign_arr",   arr_c, exp_arr);
    chk("wait_ign_state", {fill_c, req_c, wait_c, show_c}, 4'b0010);
    chk("wait_start",     start_c, 1'b0);

    DetBusy = 1'b0; DetDone = 1'b1;
    tick();
    chk("done_show", show_c, 1'b1);
    press_back();
    chk("show_back_state", {fill_c, req_c, wait_c, show_c}, 4'b0001);
    chk("show_back_ack",   ack_c, 1'b0);
    chk("show_back_arr",   arr_c, exp_arr);

    BtnEnter = 1'b1;
    tick();
    chk("ack_rise", ack_c, 1'b1);
    BtnEnter = 1'b0;
    tick();
    chk("ack_held", ack_c, 1'b1);
    chk("ack_show", show_c, 1'b1);

    DetDone = 1'b0;
    tick();
    chk("ack_fall",  ack_c, 1'b0);
    chk("ret_idx",   idx_c, 6'd0);
    chk("ret_fill",  fill_c, 1'b1);
    chk("ret_clear", arr_c, '0);
    chk("ret_keep",  arr_k, exp_arr);
    chk("ret_keep_fill", fill_k, 1'b1);

    // Second matrix, then reset while the engine is busy and Enter is held.
    for (int k = 0; k < 64; k++) press_enter(4'd2);
    chk("m2_req", req_c, 1'b1);
    DetBusy = 1'b1;
    tick();
    chk("m2_wait", wait_c, 1'b1);
    BtnEnter = 1'b1; Din = 4'd9;
    Reset = 1'b1;
    #2;
    chk("arst_state", {fill_c, req_c, wait_c, show_c}, 4'b1000);
    chk("arst_start", start_c, 1'b0);
    chk("arst_ack",   ack_c, 1'b0);
    chk("arst_idx",   idx_c, 6'd0);
    chk("arst_arr",   arr_c, '0);
    chk("arst_arrk",  arr_k, '0);
    tick();
    Reset = 1'b0; DetBusy = 1'b0;
    repeat (3) tick();
    chk("held_idx", idx_c, 6'd0);
    chk("held_arr", arr_c, '0);
    BtnEnter = 1'b0;
    tick();
    BtnEnter = 1'b1;
    tick();
    chk("repress_idx", idx_c, 6'd1);
    chk("repress_e0",  ent(arr_c, 0), 4'd9);
    BtnEnter = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
